// File: rtl/seqdet_ctx_scheduler_if.sv
// Bus bundle for seqdet_ctx_scheduler: per-channel request/bit/clear inputs and grant/match/update outputs.
// hit_cnt exists only when SEQDET_HIT_COUNT_EN is defined.
interface seqdet_ctx_scheduler_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  localparam int CHW = $clog2(N_CH);

  logic [N_CH-1:0] req;
  logic [N_CH-1:0] w;
  logic [N_CH-1:0] clr;
  logic [N_CH-1:0] gnt;
  logic [N_CH-1:0] z;
  logic            upd_valid;
  logic [CHW-1:0]  upd_chan;
  logic            upd_z;
`ifdef SEQDET_HIT_COUNT_EN
  logic [N_CH*CNT_W-1:0] hit_cnt;

  modport master (output req, w, clr, input gnt, z, upd_valid, upd_chan, upd_z, hit_cnt);
  modport slave  (input req, w, clr, output gnt, z, upd_valid, upd_chan, upd_z, hit_cnt);
`else
  modport master (output req, w, clr, input gnt, z, upd_valid, upd_chan, upd_z);
  modport slave  (input req, w, clr, output gnt, z, upd_valid, upd_chan, upd_z);
`endif
endinterface

// File: rtl/seqdet_ctx_scheduler.sv
// One 6-state Moore pattern detector time-shared across N_CH channels via a round-robin arbiter.
// Optional per-channel saturating hit counters are enabled by defining SEQDET_HIT_COUNT_EN.
module seqdet_ctx_scheduler #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  seqdet_ctx_scheduler_if.slave  bus
);
  localparam int          CHW = $clog2(N_CH);
  localparam int unsigned NU  = N_CH;

  typedef enum logic [2:0] {
    ST_A = 3'd0, ST_B = 3'd1, ST_C = 3'd2, ST_D = 3'd3, ST_E = 3'd4, ST_F = 3'd5
  } state_t;

  state_t          ctx_q [N_CH];
  state_t          ctx_d [N_CH];
  logic [CHW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CHW-1:0]  upd_chan_q, upd_chan_d;
  logic            upd_valid_q, upd_valid_d;
  logic            upd_z_q, upd_z_d;
  logic [CHW-1:0]  gnt_idx, cand;
  logic            gnt_any;
  logic [N_CH-1:0] gnt_c, z_c;

  function automatic logic is_ef(state_t s);
    return (s == ST_E) || (s == ST_F);
  endfunction

  // Codes 6 and 7 fall through to default and recover to A.
  function automatic state_t next_state(state_t s, logic wb);
    case (s)
      ST_A:    return wb ? ST_A : ST_B;
      ST_B:    return wb ? ST_D : ST_C;
      ST_C:    return wb ? ST_D : ST_E;
      ST_D:    return wb ? ST_A : ST_F;
      ST_E:    return wb ? ST_D : ST_E;
      ST_F:    return wb ? ST_D : ST_C;
      default: return ST_A;
    endcase
  endfunction

  always_comb begin
    gnt_c   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      cand = CHW'((32'(rr_ptr_q) + i) % NU);
      if (!gnt_any && bus.req[cand]) begin
        gnt_any      = 1'b1;
        gnt_idx      = cand;
        gnt_c[cand]  = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NU; c++) begin
      ctx_d[c] = ctx_q[c];
      if (bus.clr[c])
        ctx_d[c] = ST_A;
      else if (gnt_c[c])
        ctx_d[c] = next_state(ctx_q[c], bus.w[c]);
      z_c[c] = is_ef(ctx_q[c]);
    end
    rr_ptr_d = rr_ptr_q;
    if (gnt_any)
      rr_ptr_d = (gnt_idx == CHW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
    upd_valid_d = gnt_any;
    upd_chan_d  = gnt_any ? gnt_idx : upd_chan_q;
    upd_z_d     = gnt_any && is_ef(ctx_d[gnt_idx]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NU; c++) ctx_q[c] <= ST_A;
      rr_ptr_q    <= '0;
      upd_valid_q <= 1'b0;
      upd_chan_q  <= '0;
      upd_z_q     <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NU; c++) ctx_q[c] <= ctx_d[c];
      rr_ptr_q    <= rr_ptr_d;
      upd_valid_q <= upd_valid_d;
      upd_chan_q  <= upd_chan_d;
      upd_z_q     <= upd_z_d;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.z         = z_c;
  assign bus.upd_valid = upd_valid_q;
  assign bus.upd_chan  = upd_chan_q;
  assign bus.upd_z     = upd_z_q;

`ifdef SEQDET_HIT_COUNT_EN
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  // A hit is an entry into {E,F} from outside it; staying in E/F does not count.
  always_comb begin
    for (int unsigned c = 0; c < NU; c++) begin
      cnt_d[c] = cnt_q[c];
      if (bus.clr[c])
        cnt_d[c] = '0;
      else if (gnt_c[c] && !is_ef(ctx_q[c]) && is_ef(ctx_d[c]) && (cnt_q[c] != '1))
        cnt_d[c] = cnt_q[c] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NU; c++) cnt_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NU; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  always_comb begin
    bus.hit_cnt = '0;
    for (int unsigned c = 0; c < NU; c++)
      bus.hit_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
  end
`endif
endmodule

// File: tb/tb_seqdet_ctx_scheduler.sv
// Scoreboard bench for seqdet_ctx_scheduler: directed scenarios then random traffic against a table-driven model.
module tb_seqdet_ctx_scheduler;
  localparam int N  = 4;
  localparam int CW = 8;

  logic clk;
  logic reset;

  seqdet_ctx_scheduler_if #(.N_CH(N), .CNT_W(CW)) bus ();

  seqdet_ctx_scheduler #(.N_CH(N), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: state codes A..F = 0..5, next-state lookup tables by w.
  int nx1 [6] = '{0, 3, 3, 0, 3, 3};
  int nx0 [6] = '{1, 2, 4, 5, 4, 2};
  int st  [N] = '{0, 0, 0, 0};
  int cnt [N] = '{0, 0, 0, 0};
  int ptr = 0;

  int q_chan [$];
  int q_z    [$];

  function automatic bit ef(int s);
    return (s == 4) || (s == 5);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] wv,
                      input logic [N-1:0] cl, input logic rs);
    int g;
    int exp_gnt;
    int old_s;
    int new_s;
    @(negedge clk);
    bus.req = r;
    bus.w   = wv;
    bus.clr = cl;
    reset   = rs;
    #1;
    g = -1;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (ptr + i) % N;
      if (g < 0 && r[idx]) g = idx;
    end
    exp_gnt = (g < 0) ? 0 : (1 << g);
    chk("gnt", int'(bus.gnt), exp_gnt);
    if (rs) begin
      for (int c = 0; c < N; c++) begin
        st[c]  = 0;
        cnt[c] = 0;
      end
      ptr = 0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (cl[c]) begin
          st[c]  = 0;
          cnt[c] = 0;
        end else if (c == g) begin
          old_s = st[c];
          new_s = (old_s > 5) ? 0 : (wv[c] ? nx1[old_s] : nx0[old_s]);
          st[c] = new_s;
          if (!ef(old_s) && ef(new_s) && cnt[c] < 255) cnt[c]++;
        end
      end
      if (g >= 0) begin
        ptr = (g + 1) % N;
        q_chan.push_back(g);
        q_z.push_back(int'(ef(st[g])));
      end
    end
  endtask

  // Monitor: compares registered outputs shortly after every rising edge.
  initial begin
    int exp_z;
    int ec;
    int ez;
    forever begin
      @(posedge clk);
      #2;
      chk("upd_valid", int'(bus.upd_valid), int'(q_chan.size() > 0));
      if (bus.upd_valid && q_chan.size() > 0) begin
        ec = q_chan.pop_front();
        ez = q_z.pop_front();
        chk("upd_chan", int'(bus.upd_chan), ec);
        chk("upd_z", int'(bus.upd_z), ez);
      end
      exp_z = 0;
      for (int c = 0; c < N; c++) if (ef(st[c])) exp_z |= (1 << c);
      chk("z", int'(bus.z), exp_z);
`ifdef SEQDET_HIT_COUNT_EN
      for (int c = 0; c < N; c++) begin
        logic [N*CW-1:0] hc;
        hc = bus.hit_cnt;
        chk("hit_cnt", int'(hc[c*CW +: CW]), cnt[c]);
      end
`endif
    end
  end

  initial begin
    bus.req = '0;
    bus.w   = '0;
    bus.clr = '0;
    reset   = 1'b1;

    // Reset then idle
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    repeat (5) step(4'b0000, 4'b0000, 4'b0000, 1'b0);

    // All channels requesting: full rotation twice
    repeat (8) step(4'b1111, 4'b0000, 4'b0000, 1'b0);

    // ch1 alone: 0,0,0 -> E, 1 -> D, 0 -> F
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(4'b0010, 4'b0000, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 4'b0000, 1'b0);
    step(4'b0010, 4'b0010, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 4'b0000, 1'b0);

    // ch0 (w=0) and ch2 (w=1) interleaved
    repeat (6) step(4'b0101, 4'b0100, 4'b0000, 1'b0);

    // ch3 driven into E, then cleared on the same cycle it is granted
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    repeat (3) step(4'b1000, 4'b0000, 4'b0000, 1'b0);
    step(4'b1000, 4'b0000, 4'b1000, 1'b0);
    repeat (4) step(4'b1111, 4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 4'b1111, 1'b0);

    // ch1 in F, reset mid-stream, then lowest requester wins
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(4'b0010, 4'b0000, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 4'b0000, 1'b0);
    step(4'b0010, 4'b0010, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 4'b0000, 1'b0);
    step(4'b1111, 4'b0000, 4'b0000, 1'b1);
    step(4'b0110, 4'b0000, 4'b0000, 1'b0);
    step(4'b0110, 4'b0000, 4'b0000, 1'b0);

    // ch0: repeated entries into E/F (exercises counter saturation when enabled)
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    repeat (3) step(4'b0001, 4'b0000, 4'b0000, 1'b0);
    repeat (300) begin
      step(4'b0001, 4'b0001, 4'b0000, 1'b0);
      step(4'b0001, 4'b0000, 4'b0000, 1'b0);
    end

    // Random traffic
    repeat (2000) begin
      logic [N-1:0] r, wv, cl;
      logic rs;
      r  = N'($urandom);
      wv = N'($urandom);
      cl = '0;
      for (int c = 0; c < N; c++) if ($urandom_range(15) == 0) cl[c] = 1'b1;
      rs = ($urandom_range(199) == 0);
      step(r, wv, cl, rs);
    end

    step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    chk("scoreboard_drained", q_chan.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
